// File: rtl/sram_arb_pkg.sv
// Shared definitions for the external SRAM port arbiter.
//  - Fixed master map: VGA pixel fetch, UART loader, compressor/decoder datapath.
//  - Lock-tracking FSM state type.
//  - Read-return tag carried down the latency pipeline: {valid, master id}.
package sram_arb_pkg;

   localparam int REQ_VGA  = 0;
   localparam int REQ_UART = 1;
   localparam int REQ_DEC  = 2;

   // Master id width, $clog2(3); the tag is ID_W+1 bits.
   localparam int ID_W = 2;

   typedef enum logic {
      S_ARB_FREE,
      S_ARB_LOCKED
   } arb_state_t;

   typedef struct packed {
      logic            valid;
      logic [ID_W-1:0] id;
   } rd_tag_t;

endpackage

// File: rtl/sram_rr_picker.sv
// Two-way round-robin picker for the non-VGA masters (UART and DEC).
// Ports:
//   clk, rst     : clock, synchronous active-high reset
//   req_i[1:0]   : [0]=UART request, [1]=DEC request
//   lock_act_i   : a lock is in force; only the owner is eligible
//   lock_own_i   : lock owner, 0=UART, 1=DEC
//   adv_i        : this cycle's pick is actually granted (no VGA override)
//   pick_o[1:0]  : one-hot (or zero) pick, same bit order as req_i
// The pointer remembers the last granted master; the other one has priority
// on a tie. Reset leaves DEC as the last winner, so UART wins the first tie.
module sram_rr_picker (
   input  logic       clk,
   input  logic       rst,
   input  logic [1:0] req_i,
   input  logic       lock_act_i,
   input  logic       lock_own_i,
   input  logic       adv_i,
   output logic [1:0] pick_o
);

   logic       last_q;
   logic       last_d;
   logic [1:0] eligible;

   always_comb begin
      eligible = req_i;
      if (lock_act_i) begin
         eligible = lock_own_i ? (req_i & 2'b10) : (req_i & 2'b01);
      end

      if (eligible == 2'b11) begin
         pick_o = last_q ? 2'b01 : 2'b10;
      end else begin
         pick_o = eligible;
      end

      // Pointer moves only when the pick is really granted.
      last_d = last_q;
      if (adv_i && (pick_o != 2'b00)) begin
         last_d = pick_o[1];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         last_q <= 1'b1;
      end else begin
         last_q <= last_d;
      end
   end

endmodule

// File: rtl/sram_port_arbiter.sv
// Arbiter sharing the single 256Kx16 external SRAM port among three masters:
// VGA pixel fetch (index 0, fixed highest priority), UART loader (index 1) and
// decoder datapath (index 2); UART and DEC share round-robin with an optional lock.
// Ports:
//   Clock_50, Reset        : clock, synchronous active-high reset
//   req_i/we_i/lock_i      : per-master request, write flag, lock hold
//   addr_i/wdata_i         : packed per-master address / write data (master k at k*W)
//   grant_o                : combinational one-hot grant, access accepted this cycle
//   rvalid_o/rdata_o       : read return, READ_LATENCY cycles after the grant cycle
//   SRAM_address_o, SRAM_write_data_o, SRAM_we_n_o : registered SRAM controls
//   SRAM_read_data_i       : read data from the SRAM interface
// READ_LATENCY must be at least 2 (data register is loaded one stage early).
module sram_port_arbiter
   import sram_arb_pkg::*;
#(
   parameter int NUM_REQ      = 3,
   parameter int ADDR_W       = 18,
   parameter int DATA_W       = 16,
   parameter int READ_LATENCY = 3
) (
   input  logic                      Clock_50,
   input  logic                      Reset,
   input  logic [NUM_REQ-1:0]        req_i,
   input  logic [NUM_REQ-1:0]        we_i,
   input  logic [NUM_REQ-1:0]        lock_i,
   input  logic [NUM_REQ*ADDR_W-1:0] addr_i,
   input  logic [NUM_REQ*DATA_W-1:0] wdata_i,
   output logic [NUM_REQ-1:0]        grant_o,
   output logic [NUM_REQ-1:0]        rvalid_o,
   output logic [DATA_W-1:0]         rdata_o,
   output logic [ADDR_W-1:0]         SRAM_address_o,
   output logic [DATA_W-1:0]         SRAM_write_data_o,
   output logic                      SRAM_we_n_o,
   input  logic [DATA_W-1:0]         SRAM_read_data_i
);

   arb_state_t        state_q, state_d;
   logic              owner_q, owner_d;   // 0=UART, 1=DEC

   logic              owner_req;
   logic              owner_lock;
   logic              lock_act;
   logic              rr_adv;
   logic [1:0]        rr_pick;

   logic              any_gnt;
   logic              win_we;
   logic              win_lock;
   logic [ID_W-1:0]   win_idx;
   logic [ADDR_W-1:0] win_addr;
   logic [DATA_W-1:0] win_wdata;

   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic              we_n_q, we_n_d;
   logic [DATA_W-1:0] rdata_q, rdata_d;
   rd_tag_t           tag_q [READ_LATENCY];
   rd_tag_t           tag_d [READ_LATENCY];

   // The lock only holds while its owner keeps both req and lock high; it
   // drops in the very cycle either goes low, so the other master can win then.
   always_comb begin
      owner_req  = owner_q ? req_i[REQ_DEC]  : req_i[REQ_UART];
      owner_lock = owner_q ? lock_i[REQ_DEC] : lock_i[REQ_UART];
      lock_act   = (state_q == S_ARB_LOCKED) && owner_req && owner_lock;
      rr_adv     = !Reset && !req_i[REQ_VGA];
   end

   sram_rr_picker u_rr_picker (
      .clk        (Clock_50),
      .rst        (Reset),
      .req_i      ({req_i[REQ_DEC], req_i[REQ_UART]}),
      .lock_act_i (lock_act),
      .lock_own_i (owner_q),
      .adv_i      (rr_adv),
      .pick_o     (rr_pick)
   );

   // VGA overrides everything, including a held lock.
   always_comb begin
      grant_o = '0;
      if (!Reset) begin
         if (req_i[REQ_VGA]) begin
            grant_o[REQ_VGA] = 1'b1;
         end else begin
            grant_o[REQ_UART] = rr_pick[0];
            grant_o[REQ_DEC]  = rr_pick[1];
         end
      end
   end

   always_comb begin
      any_gnt   = |grant_o;
      win_idx   = '0;
      win_we    = 1'b0;
      win_lock  = 1'b0;
      win_addr  = '0;
      win_wdata = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         if (grant_o[k]) begin
            win_idx   = ID_W'(k);
            win_we    = we_i[k];
            win_lock  = lock_i[k];
            win_addr  = addr_i[k*ADDR_W +: ADDR_W];
            win_wdata = wdata_i[k*DATA_W +: DATA_W];
         end
      end
   end

   // Lock FSM: a VGA grant leaves a live lock untouched.
   always_comb begin
      state_d = state_q;
      owner_d = owner_q;
      if (!lock_act) begin
         state_d = S_ARB_FREE;
      end
      if (any_gnt && (win_idx != ID_W'(REQ_VGA)) && win_lock) begin
         state_d = S_ARB_LOCKED;
         owner_d = (win_idx == ID_W'(REQ_DEC));
      end
   end

   always_comb begin
      addr_d  = addr_q;
      wdata_d = wdata_q;
      we_n_d  = 1'b1;
      if (any_gnt) begin
         addr_d  = win_addr;
         wdata_d = win_wdata;
         we_n_d  = !win_we;
      end

      tag_d[0].valid = any_gnt && !win_we;
      tag_d[0].id    = win_idx;
      for (int i = 1; i < READ_LATENCY; i++) begin
         tag_d[i] = tag_q[i-1];
      end

      // Data arrives one stage before the tag reaches the output.
      rdata_d = rdata_q;
      if (tag_q[READ_LATENCY-2].valid) begin
         rdata_d = SRAM_read_data_i;
      end
   end

   // Stage boundary: grant cycle -> SRAM bus / tag pipeline / return register
   always_ff @(posedge Clock_50) begin
      if (Reset) begin
         state_q <= S_ARB_FREE;
         owner_q <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         we_n_q  <= 1'b1;
         rdata_q <= '0;
         for (int i = 0; i < READ_LATENCY; i++) begin
            tag_q[i] <= '0;
         end
      end else begin
         state_q <= state_d;
         owner_q <= owner_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         we_n_q  <= we_n_d;
         rdata_q <= rdata_d;
         for (int i = 0; i < READ_LATENCY; i++) begin
            tag_q[i] <= tag_d[i];
         end
      end
   end

   always_comb begin
      for (int k = 0; k < NUM_REQ; k++) begin
         rvalid_o[k] = tag_q[READ_LATENCY-1].valid && (tag_q[READ_LATENCY-1].id == ID_W'(k));
      end
   end

   assign rdata_o           = rdata_q;
   assign SRAM_address_o    = addr_q;
   assign SRAM_write_data_o = wdata_q;
   assign SRAM_we_n_o       = we_n_q;

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Directed bench for sram_port_arbiter with a one-cycle-registered SRAM model.
module tb_sram_port_arbiter;

   localparam int NUM_REQ = 3;
   localparam int ADDR_W  = 18;
   localparam int DATA_W  = 16;

   logic                      Clock_50 = 1'b0;
   logic                      Reset;
   logic [NUM_REQ-1:0]        req_i, we_i, lock_i;
   logic [NUM_REQ*ADDR_W-1:0] addr_i;
   logic [NUM_REQ*DATA_W-1:0] wdata_i;
   logic [NUM_REQ-1:0]        grant_o, rvalid_o;
   logic [DATA_W-1:0]         rdata_o;
   logic [ADDR_W-1:0]         SRAM_address_o;
   logic [DATA_W-1:0]         SRAM_write_data_o;
   logic                      SRAM_we_n_o;
   logic [DATA_W-1:0]         sram_rd;

   logic [DATA_W-1:0]         mem [0:262143];
   logic                      preload;

   int n_checks = 0;
   int n_errors = 0;

   sram_port_arbiter dut (
      .Clock_50          (Clock_50),
      .Reset             (Reset),
      .req_i             (req_i),
      .we_i              (we_i),
      .lock_i            (lock_i),
      .addr_i            (addr_i),
      .wdata_i           (wdata_i),
      .grant_o           (grant_o),
      .rvalid_o          (rvalid_o),
      .rdata_o           (rdata_o),
      .SRAM_address_o    (SRAM_address_o),
      .SRAM_write_data_o (SRAM_write_data_o),
      .SRAM_we_n_o       (SRAM_we_n_o),
      .SRAM_read_data_i  (sram_rd)
   );

   always #5 Clock_50 = ~Clock_50;

   // SRAM model: address on the bus in cycle n, data visible in cycle n+1.
   always @(posedge Clock_50) begin
      if (preload) begin
         mem[18'h00100] <= 16'hBEEF;
         for (int a = 0; a < 8; a++) mem[18'(a)] <= 16'hA000 + 16'(a);
      end else if (!SRAM_we_n_o) begin
         mem[SRAM_address_o] <= SRAM_write_data_o;
      end
      sram_rd <= mem[SRAM_address_o];
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge Clock_50);
      #1;
   endtask

   task automatic idle();
      req_i  = '0;
      we_i   = '0;
      lock_i = '0;
   endtask

   task automatic set_m(input int k, input logic r, input logic w, input logic l,
                        input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
      req_i[k]  = r;
      we_i[k]   = w;
      lock_i[k] = l;
      addr_i[k*ADDR_W +: ADDR_W] = a;
      wdata_i[k*DATA_W +: DATA_W] = d;
   endtask

   logic [2:0] g2   [7] = '{3'b001, 3'b001, 3'b001, 3'b010, 3'b100, 3'b010, 3'b100};
   logic [2:0] req4 [7] = '{3'b100, 3'b110, 3'b110, 3'b111, 3'b110, 3'b110, 3'b100};
   logic [2:0] lck4 [7] = '{3'b100, 3'b100, 3'b100, 3'b100, 3'b100, 3'b000, 3'b000};
   logic [2:0] g4   [7] = '{3'b100, 3'b100, 3'b100, 3'b001, 3'b100, 3'b010, 3'b100};

   initial begin
      Reset = 1'b1; preload = 1'b1;
      idle(); addr_i = '0; wdata_i = '0;
      step(); step();
      req_i = 3'b111;
      @(negedge Clock_50);
      check("rst_grant", 32'(grant_o), 32'h0);
      check("rst_rvalid", 32'(rvalid_o), 32'h0);
      check("rst_rdata", 32'(rdata_o), 32'h0);
      check("rst_addr", 32'(SRAM_address_o), 32'h0);
      check("rst_wdata", 32'(SRAM_write_data_o), 32'h0);
      check("rst_we_n", 32'(SRAM_we_n_o), 32'h1);

      step(); Reset = 1'b0; preload = 1'b0; idle();
      @(negedge Clock_50);
      check("idle_grant", 32'(grant_o), 32'h0);

      // Reset during an in-flight DEC read
      step(); set_m(2, 1'b1, 1'b0, 1'b0, 18'h00100, 16'h0);
      @(negedge Clock_50);
      check("t1_grant", 32'(grant_o), 32'h4);
      step(); Reset = 1'b1; idle();
      @(negedge Clock_50);
      check("t1_grant_in_rst", 32'(grant_o), 32'h0);
      step(); Reset = 1'b0;
      @(negedge Clock_50);
      check("t1_addr", 32'(SRAM_address_o), 32'h0);
      check("t1_we_n", 32'(SRAM_we_n_o), 32'h1);
      check("t1_rdata", 32'(rdata_o), 32'h0);
      check("t1_rvalid", 32'(rvalid_o), 32'h0);
      for (int i = 0; i < 3; i++) begin
         step();
         @(negedge Clock_50);
         check("t1_rvalid", 32'(rvalid_o), 32'h0);
      end

      // VGA priority, then UART/DEC alternation
      for (int c = 0; c < 7; c++) begin
         step();
         if (c == 0) begin
            set_m(0, 1'b1, 1'b0, 1'b0, 18'h00010, 16'h0);
            set_m(1, 1'b1, 1'b0, 1'b0, 18'h00011, 16'h0);
            set_m(2, 1'b1, 1'b0, 1'b0, 18'h00012, 16'h0);
         end
         if (c == 3) req_i[0] = 1'b0;
         @(negedge Clock_50);
         check("t2_prio", 32'(grant_o), 32'(g2[c]));
      end
      step(); idle();
      for (int i = 0; i < 4; i++) step();

      // Read latency
      set_m(2, 1'b1, 1'b0, 1'b0, 18'h00100, 16'h0);
      @(negedge Clock_50);
      check("t3_grant", 32'(grant_o), 32'h4);
      check("t3_rvalid0", 32'(rvalid_o), 32'h0);
      for (int c = 1; c <= 4; c++) begin
         step();
         if (c == 1) idle();
         @(negedge Clock_50);
         if (c == 1) begin
            check("t3_addr", 32'(SRAM_address_o), 32'h00100);
            check("t3_we_n", 32'(SRAM_we_n_o), 32'h1);
         end
         check("t3_rvalid", 32'(rvalid_o), (c == 3) ? 32'h4 : 32'h0);
         if (c == 3) check("t3_rdata", 32'(rdata_o), 32'hBEEF);
      end

      // DEC lock burst with UART waiting and a VGA preemption
      set_m(0, 1'b0, 1'b0, 1'b0, 18'h00000, 16'h0);
      set_m(1, 1'b0, 1'b1, 1'b0, 18'h00300, 16'h0300);
      set_m(2, 1'b0, 1'b1, 1'b0, 18'h00200, 16'h0D00);
      for (int c = 0; c < 7; c++) begin
         step();
         req_i  = req4[c];
         lock_i = lck4[c];
         we_i   = 3'b110;
         @(negedge Clock_50);
         check("t4_lock", 32'(grant_o), 32'(g4[c]));
      end
      step(); idle();
      @(negedge Clock_50);
      check("t4_idle", 32'(grant_o), 32'h0);
      for (int i = 0; i < 4; i++) step();

      // Write to top address then read it straight back
      set_m(1, 1'b1, 1'b1, 1'b0, 18'h3FFFF, 16'h1234);
      @(negedge Clock_50);
      check("t5_wgrant", 32'(grant_o), 32'h2);
      step();
      set_m(1, 1'b0, 1'b0, 1'b0, 18'h3FFFF, 16'h1234);
      set_m(2, 1'b1, 1'b0, 1'b0, 18'h3FFFF, 16'h0);
      @(negedge Clock_50);
      check("t5_rgrant", 32'(grant_o), 32'h4);
      check("t5_we_n_wr", 32'(SRAM_we_n_o), 32'h0);
      check("t5_addr_wr", 32'(SRAM_address_o), 32'h3FFFF);
      check("t5_wdata", 32'(SRAM_write_data_o), 32'h1234);
      step(); idle();
      @(negedge Clock_50);
      check("t5_we_n_rd", 32'(SRAM_we_n_o), 32'h1);
      check("t5_addr_rd", 32'(SRAM_address_o), 32'h3FFFF);
      check("t5_rvalid", 32'(rvalid_o), 32'h0);
      step();
      @(negedge Clock_50);
      check("t5_rvalid", 32'(rvalid_o), 32'h0);
      step();
      @(negedge Clock_50);
      check("t5_rvalid_ret", 32'(rvalid_o), 32'h4);
      check("t5_rdata", 32'(rdata_o), 32'h1234);

      // Pipelined VGA reads of addresses 0..7
      for (int c = 0; c < 12; c++) begin
         step();
         if (c < 8) set_m(0, 1'b1, 1'b0, 1'b0, 18'(c), 16'h0);
         else idle();
         @(negedge Clock_50);
         check("t6_grant", 32'(grant_o), (c < 8) ? 32'h1 : 32'h0);
         check("t6_rvalid", 32'(rvalid_o), (c >= 3 && c < 11) ? 32'h1 : 32'h0);
         if (c >= 3 && c < 11) check("t6_rdata", 32'(rdata_o), 32'hA000 + 32'(c - 3));
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
